// File: rtl/axi_mem_pkg.sv
// Shared burst/response encodings, FSM state types and response ranking for axi_mem_slave.
package axi_mem_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

  // The codes in use rank OKAY < SLVERR < DECERR numerically, so the worse one is the larger.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Next-beat byte address for an AXI4 burst (FIXED, INCR, WRAP; illegal WRAP lengths step as INCR).
// Latency: purely combinational.
// Backpressure: none; the caller decides when to take next_addr.
module axi_burst_addr
  import axi_mem_pkg::*;
(
  input  logic [63:0] addr,
  input  logic [7:0]  len,
  input  logic [2:0]  size,
  input  logic [1:0]  burst,
  output logic [63:0] next_addr
);

  logic [63:0] step;
  logic [63:0] incr_addr;
  logic [63:0] wrap_mask;
  logic        wrap_ok;

  always_comb begin
    step      = 64'd1 << size;
    incr_addr = addr + step;
    wrap_mask = (({56'd0, len} + 64'd1) << size) - 64'd1;
    wrap_ok   = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    next_addr = incr_addr;
    if (burst == BURST_FIXED) begin
      next_addr = addr;
    end else if ((burst == BURST_WRAP) && wrap_ok) begin
      // Keep the bits above the wrap window, let the low bits roll over inside it.
      next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
    end
  end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 responder backed by a DEPTH x 64-bit array; define AXI_MEM_DECERR_EN to answer DECERR outside the mapped window.
// Latency: B one cycle after the last W handshake; first R beat one cycle after AR, then beats stream back to back.
// Backpressure: one burst per direction; AWREADY/ARREADY stay low until B / last R handshake; RREADY low holds the beat.
module axi_mem_slave
  import axi_mem_pkg::*;
#(
  parameter int          DEPTH     = 8192,
  parameter int          ID_W      = 4,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic            sys_clk,
  input  logic            RST,
  input  logic [ID_W-1:0] S_AXI_AWID,
  input  logic [63:0]     S_AXI_AWADDR,
  input  logic [7:0]      S_AXI_AWLEN,
  input  logic [2:0]      S_AXI_AWSIZE,
  input  logic [1:0]      S_AXI_AWBURST,
  input  logic            S_AXI_AWVALID,
  output logic            S_AXI_AWREADY,
  input  logic [63:0]     S_AXI_WDATA,
  input  logic [7:0]      S_AXI_WSTRB,
  input  logic            S_AXI_WLAST,
  input  logic            S_AXI_WVALID,
  output logic            S_AXI_WREADY,
  output logic [ID_W-1:0] S_AXI_BID,
  output logic [1:0]      S_AXI_BRESP,
  output logic            S_AXI_BVALID,
  input  logic            S_AXI_BREADY,
  input  logic [ID_W-1:0] S_AXI_ARID,
  input  logic [63:0]     S_AXI_ARADDR,
  input  logic [7:0]      S_AXI_ARLEN,
  input  logic [2:0]      S_AXI_ARSIZE,
  input  logic [1:0]      S_AXI_ARBURST,
  input  logic            S_AXI_ARVALID,
  output logic            S_AXI_ARREADY,
  output logic [ID_W-1:0] S_AXI_RID,
  output logic [63:0]     S_AXI_RDATA,
  output logic [1:0]      S_AXI_RRESP,
  output logic            S_AXI_RLAST,
  output logic            S_AXI_RVALID,
  input  logic            S_AXI_RREADY
);

  localparam int IDX_W = $clog2(DEPTH);

  function automatic logic [IDX_W-1:0] word_idx(input logic [63:0] a);
    return IDX_W'((a - BASE_ADDR) >> 3);
  endfunction

`ifdef AXI_MEM_DECERR_EN
  function automatic logic in_range(input logic [63:0] a);
    return (a - BASE_ADDR) < (64'(DEPTH) << 3);
  endfunction
`endif

  logic [63:0] mem [DEPTH];

  wr_state_t       w_state, w_state_nxt;
  logic [ID_W-1:0] aw_id;
  logic [63:0]     aw_addr, w_next;
  logic [7:0]      aw_len, w_cnt;
  logic [2:0]      aw_size;
  logic [1:0]      aw_burst, w_resp, w_beat_resp;
  logic            w_wen, aw_fire, w_fire;

  rd_state_t       r_state, r_state_nxt;
  logic [ID_W-1:0] ar_id;
  logic [63:0]     r_addr, r_next, ld_addr, rd_word;
  logic [7:0]      ar_len, r_cnt;
  logic [2:0]      ar_size;
  logic [1:0]      ar_burst, rresp_q, ld_resp;
  logic            rlast_q, rd_zero, ld_zero, ar_fire, r_fire, r_load;

  axi_burst_addr u_wr_addr (.addr(aw_addr), .len(aw_len), .size(aw_size), .burst(aw_burst), .next_addr(w_next));
  axi_burst_addr u_rd_addr (.addr(r_addr),  .len(ar_len), .size(ar_size), .burst(ar_burst), .next_addr(r_next));

  always_ff @(posedge sys_clk) begin
    if (RST) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = w_state;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    case (w_state)
      W_IDLE: begin
        S_AXI_AWREADY = 1'b1;
        if (S_AXI_AWVALID) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        S_AXI_WREADY = 1'b1;
        if (S_AXI_WVALID && S_AXI_WLAST) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        S_AXI_BVALID = 1'b1;
        if (S_AXI_BREADY) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_nxt   = r_state;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    case (r_state)
      R_IDLE: begin
        S_AXI_ARREADY = 1'b1;
        if (S_AXI_ARVALID) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        S_AXI_RVALID = 1'b1;
        if (S_AXI_RREADY && rlast_q) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  assign aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_fire  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_fire = S_AXI_ARVALID && S_AXI_ARREADY;
  assign r_fire  = S_AXI_RVALID && S_AXI_RREADY;
  assign r_load  = ar_fire || (r_fire && !rlast_q);

  // A WLAST that disagrees with the beat counter (early or late) marks the burst SLVERR.
  always_comb begin
    w_beat_resp = (aw_size > 3'd3) ? RESP_SLVERR : RESP_OKAY;
    if (S_AXI_WLAST != (w_cnt == aw_len)) w_beat_resp = RESP_SLVERR;
    w_wen = (aw_size <= 3'd3);
`ifdef AXI_MEM_DECERR_EN
    if (!in_range(aw_addr)) begin
      w_beat_resp = RESP_DECERR;
      w_wen       = 1'b0;
    end
`endif
  end

  always_ff @(posedge sys_clk) begin
    if (RST) begin
      aw_id    <= '0;
      aw_addr  <= '0;
      aw_len   <= '0;
      aw_size  <= '0;
      aw_burst <= '0;
      w_cnt    <= '0;
      w_resp   <= RESP_OKAY;
    end else if (aw_fire) begin
      aw_id    <= S_AXI_AWID;
      aw_addr  <= S_AXI_AWADDR;
      aw_len   <= S_AXI_AWLEN;
      aw_size  <= S_AXI_AWSIZE;
      aw_burst <= S_AXI_AWBURST;
      w_cnt    <= '0;
      w_resp   <= RESP_OKAY;
    end else if (w_fire) begin
      aw_addr  <= w_next;
      w_cnt    <= w_cnt + 8'd1;
      w_resp   <= resp_max(w_resp, w_beat_resp);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_fire && w_wen && !RST) begin
      for (int b = 0; b < 8; b++) begin
        if (S_AXI_WSTRB[b]) mem[word_idx(aw_addr)][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  // The beat being loaded: the AR address when idle, otherwise the address after the current beat.
  always_comb begin
    ld_addr = (r_state == R_IDLE) ? S_AXI_ARADDR : r_next;
    ld_resp = (((r_state == R_IDLE) ? S_AXI_ARSIZE : ar_size) > 3'd3) ? RESP_SLVERR : RESP_OKAY;
    ld_zero = 1'b0;
`ifdef AXI_MEM_DECERR_EN
    if (!in_range(ld_addr)) begin
      ld_resp = RESP_DECERR;
      ld_zero = 1'b1;
    end
`endif
  end

  always_ff @(posedge sys_clk) begin
    if (RST) begin
      ar_id    <= '0;
      r_addr   <= '0;
      ar_len   <= '0;
      ar_size  <= '0;
      ar_burst <= '0;
      r_cnt    <= '0;
      rlast_q  <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rd_zero  <= 1'b1;
    end else if (ar_fire) begin
      ar_id    <= S_AXI_ARID;
      r_addr   <= S_AXI_ARADDR;
      ar_len   <= S_AXI_ARLEN;
      ar_size  <= S_AXI_ARSIZE;
      ar_burst <= S_AXI_ARBURST;
      r_cnt    <= '0;
      rlast_q  <= (S_AXI_ARLEN == 8'd0);
      rresp_q  <= ld_resp;
      rd_zero  <= ld_zero;
    end else if (r_fire) begin
      if (rlast_q) begin
        rlast_q <= 1'b0;
      end else begin
        r_addr  <= r_next;
        r_cnt   <= r_cnt + 8'd1;
        rlast_q <= ((r_cnt + 8'd1) == ar_len);
        rresp_q <= ld_resp;
        rd_zero <= ld_zero;
      end
    end
  end

  // Registered array read; a same-edge write lands after this sample, so the old word is returned.
  always_ff @(posedge sys_clk) begin
    if (r_load) rd_word <= mem[word_idx(ld_addr)];
  end

  assign S_AXI_BID   = aw_id;
  assign S_AXI_BRESP = w_resp;
  assign S_AXI_RID   = ar_id;
  assign S_AXI_RDATA = rd_zero ? 64'd0 : rd_word;
  assign S_AXI_RRESP = rresp_q;
  assign S_AXI_RLAST = rlast_q;

endmodule
